// File: rtl/machine_ctrl.sv
// Instruction-cycle controller: eight-step fetch/execute FSM plus sticky HALTED state,
// fully decoded control outputs and a saturating retired-instruction counter.
// Optional memory wait states are enabled with `define MACHINE_CTRL_MEM_WAIT_EN.
module machine_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic             zero,
`ifdef MACHINE_CTRL_MEM_WAIT_EN
    input  logic             mem_rdy,
`endif
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             fetch,
    output logic             halt,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t           r_state;
    state_t           w_next;
    logic             w_adv;
    logic             w_alu;
    logic             w_skip;
    logic [CNT_W-1:0] r_instr_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_alu  = (opcode >= 3'd2) && (opcode <= 3'd5);
    assign w_skip = (opcode == OP_SKZ) && zero;

    // A memory-access state waits for mem_rdy; non-memory states only need ena.
`ifdef MACHINE_CTRL_MEM_WAIT_EN
    assign w_adv = ena && (!(rd || wr) || mem_rdy);
`else
    assign w_adv = ena;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S0;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_adv) begin
            case (r_state)
                S0:      w_next = S1;
                S1:      w_next = S2;
                S2:      w_next = S3;
                S3:      w_next = (opcode == OP_HLT) ? HALTED : S4;
                S4:      w_next = S5;
                S5:      w_next = S6;
                S6:      w_next = S7;
                S7:      w_next = S0;
                HALTED:  w_next = HALTED;
                default: w_next = S0;
            endcase
        end
    end

    // Output decode, purely from {state, opcode, zero}
    always_comb begin
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        case (r_state)
            S0: begin
                rd      = 1'b1;
                load_ir = 1'b1;
            end
            S1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            S3: begin
                inc_pc = (opcode != OP_HLT);
            end
            S4: begin
                rd          = w_alu;
                load_pc     = (opcode == OP_JMP);
                datactl_ena = (opcode == OP_STO);
            end
            S5: begin
                rd          = w_alu;
                load_acc    = w_alu;
                inc_pc      = (opcode == OP_JMP) || w_skip;
                load_pc     = (opcode == OP_JMP);
                datactl_ena = (opcode == OP_STO);
                wr          = (opcode == OP_STO);
            end
            S6: begin
                rd          = w_alu;
                datactl_ena = (opcode == OP_STO);
            end
            S7: begin
                inc_pc = w_skip;
            end
            default: begin
            end
        endcase
    end

    // HALTED reports state 0 on the debug port; halt distinguishes it from S0.
    assign state = r_state[2:0];
    assign halt  = (r_state == HALTED);
    assign fetch = (r_state == S0) || (r_state == S1) || (r_state == S2) || (r_state == S3);

    // Retirement happens only on the S7->S0 step, so HLT and abandoned instructions never count.
    always_ff @(posedge clk) begin
        if (reset)
            r_instr_cnt <= '0;
        else if ((r_state == S7) && w_adv)
            r_instr_cnt <= sat_inc(r_instr_cnt);
    end

    assign instr_cnt = r_instr_cnt;

endmodule

// File: doc/machine_ctrl.md
MACHINE_CTRL -- requirements
Module: machine_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ena  input  1  step enable; the FSM advances only on edges where ena=1.
REQ-005 opcode  input  3  current instruction opcode from IR; valid from S2 onward.
REQ-006 zero  input  1  accumulator-zero flag.
REQ-007 rd, wr  output  1 each  memory read / write strobes.
REQ-008 load_ir, inc_pc, load_pc, load_acc, datactl_ena  output  1 each  datapath controls.
REQ-009 fetch  output  1  high while the FSM is in S0..S3 (instruction fetch phase).
REQ-010 halt  output  1  sticky halt indication.
REQ-011 state  output  3  current FSM state, for debug and bench monitoring.
REQ-012 instr_cnt  output  CNT_W  number of retired instructions.

Function
REQ-013 The FSM has eight cycle states S0..S7 plus HALTED, advancing S0->S1->...->S7->S0, one step per enabled edge.
REQ-014 All outputs are decoded from {state, opcode, zero} with no registered delay; ALU-op = ADD(2), AND(3), XOR(4), LDA(5).
REQ-015 S0: rd=1, load_ir=1 (high IR byte).
REQ-016 S1: rd=1, load_ir=1, inc_pc=1 (low IR byte).
REQ-017 S2: all controls 0.
REQ-018 S3: inc_pc=1, except HLT(0): inc_pc=0 and next state is HALTED.
REQ-019 S4: rd=1 for ALU-op; load_pc=1 for JMP(7); datactl_ena=1 for STO(6); all others 0.
REQ-020 S5: rd=1 and load_acc=1 for ALU-op; inc_pc=1 and load_pc=1 for JMP; datactl_ena=1 and wr=1 for STO; inc_pc=1 for SKZ(1) when zero=1.
REQ-021 S6: rd=1 for ALU-op; datactl_ena=1 for STO; all others 0.
REQ-022 S7: inc_pc=1 for SKZ when zero=1; all others 0.
REQ-023 Two inc_pc pulses in S5 and S7 skip exactly one two-byte instruction.
REQ-024 HALTED: all controls 0, halt=1, fetch=0; it is left only by reset.
REQ-025 With ena=0 the state is held, and outputs remain decoded from the held state.
REQ-026 instr_cnt increments on the S7->S0 transition and saturates at all-ones.
REQ-027 HLT is not counted.
REQ-028 rd and wr are never 1 in the same cycle.

Reset
REQ-029 When reset=1 at a rising edge, the next state is S0, halt=0 and instr_cnt=0, regardless of ena, current state or HALTED.
REQ-030 While reset is held, the state stays S0, so rd=1, load_ir=1, fetch=1 and all other controls are 0.
REQ-031 A reset mid-instruction abandons that instruction without counting it.

Configuration
REQ-032 The macro MACHINE_CTRL_MEM_WAIT_EN controls memory wait states.
REQ-033 With MACHINE_CTRL_MEM_WAIT_EN defined, the module adds input mem_rdy (1 bit).
REQ-034 When defined, any state whose decode asserts rd or wr holds (no advance, outputs unchanged) while mem_rdy=0, and advances on the first enabled edge with mem_rdy=1.
REQ-035 When defined, reset overrides the wait.
REQ-036 Without the macro, the mem_rdy port is absent and timing is exactly REQ-013..REQ-026.

Verification
REQ-037 Reset 2 cycles, then ena=1, opcode=5 (LDA) -> states 0..7 repeat every 8 clocks; rd high in S0,S1,S4,S5,S6; load_acc only in S5; instr_cnt=1 after the first S7.
REQ-038 opcode=1 (SKZ), zero=1 -> inc_pc high in S1,S3,S5,S7 (4 pulses/instr); with zero=0 -> inc_pc high in S1,S3 only.
REQ-039 opcode=6 (STO) -> wr=1 only in S5; datactl_ena=1 in S4,S5,S6; rd=0 in S4..S7.
REQ-040 opcode=0 (HLT) -> halt=1 from the cycle after S3, state stays HALTED for 20 clocks, instr_cnt unchanged; a 1-cycle reset returns to S0 with halt=0.
REQ-041 ena toggling 1,0,0,1 -> the state advances only on enabled edges; assert reset during S5 of JMP -> next state is S0, load_pc=0 and instr_cnt unchanged.
REQ-042 With MACHINE_CTRL_MEM_WAIT_EN defined, mem_rdy=0 for 3 clocks in S4 of ADD -> state=4 and rd=1 for 4 cycles, then S5 with load_acc=1; preload instr_cnt near max -> it saturates at 16'hFFFF.
